// File: rtl/seq_event_counter_pkg.sv
// Shared constants and the seven-segment lookup for seq_event_counter.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seq_event_counter_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seq_event_counter_bcd_digit.sv
// One BCD digit of the event counter: increments on carry_in when loaded,
// exposes a combinational carry_out for the ripple chain.
module bcd_digit
    import seq_event_counter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             ld,
    input  logic             carry_in,
    output logic [BCD_W-1:0] q,
    output logic             carry_out
);

    assign carry_out = carry_in & (q == 4'd9);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld && carry_in) begin
            q <= carry_out ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/seq_event_counter.sv
// Counts rising edges of the run-detector acceptance S in a DIGITS-wide BCD
// counter with sticky overflow. Define SEVEN_SEG_EN to add the HEX outputs.
module seq_event_counter
    import seq_event_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int SAT    = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    S,
    input  logic                    EN,
    input  logic                    CLR,
    output logic [BCD_W*DIGITS-1:0] COUNT,
    output logic                    EVT,
    output logic                    OVF
`ifdef SEVEN_SEG_EN
    ,
    output logic [SEG_W*DIGITS-1:0] HEX
`endif
);

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("seq_event_counter: DIGITS must be 1..4");
    end

    logic              s_d;
    logic              rise;
    logic              inc;
    logic              hold;
    logic              ld;
    logic [DIGITS:0]   carry;

    assign rise     = S & ~s_d;
    assign inc      = EN & rise & ~CLR;
    assign carry[0] = inc;
    // Saturating overflow freezes every digit at 9 instead of letting them wrap.
    assign hold     = (SAT != 0) & carry[DIGITS];
    assign ld       = ~CLR & ~hold;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .CLK       (CLK),
            .RST       (RST),
            .clr       (CLR),
            .ld        (ld),
            .carry_in  (carry[i]),
            .q         (COUNT[BCD_W*i +: BCD_W]),
            .carry_out (carry[i+1])
        );
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_d <= 1'b0;
            EVT <= 1'b0;
            OVF <= 1'b0;
        end else begin
            s_d <= S;
            if (CLR) begin
                EVT <= 1'b0;
                OVF <= 1'b0;
            end else begin
                EVT <= inc;
                if (carry[DIGITS])
                    OVF <= 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_EN
    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        assign HEX[SEG_W*i +: SEG_W] = seg_decode(COUNT[BCD_W*i +: BCD_W]);
    end
`endif

endmodule

// File: tb/tb_seq_event_counter.sv
// Randomized and directed checks of seq_event_counter (wrap and saturate
// instances side by side) against an integer-valued event model.
module tb_seq_event_counter;

    localparam int D = 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           S   = 1'b1;
    logic           EN  = 1'b1;
    logic           CLR = 1'b0;
    logic [4*D-1:0] count_w, count_s;
    logic           evt_w, evt_s, ovf_w, ovf_s;
`ifdef SEVEN_SEG_EN
    logic [7*D-1:0] hex_w, hex_s;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state, index 0 = wrap instance, 1 = saturate instance.
    int m_cnt [2];
    bit m_ovf [2];
    bit m_evt [2];
    bit m_prev;
    int maxv;

    always #5 CLK = ~CLK;

    seq_event_counter #(.DIGITS(D), .SAT(0)) u_wrap (
        .CLK(CLK), .RST(RST), .S(S), .EN(EN), .CLR(CLR),
        .COUNT(count_w), .EVT(evt_w), .OVF(ovf_w)
`ifdef SEVEN_SEG_EN
        , .HEX(hex_w)
`endif
    );

    seq_event_counter #(.DIGITS(D), .SAT(1)) u_sat (
        .CLK(CLK), .RST(RST), .S(S), .EN(EN), .CLR(CLR),
        .COUNT(count_s), .EVT(evt_s), .OVF(ovf_s)
`ifdef SEVEN_SEG_EN
        , .HEX(hex_s)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cnt_w"}, 32'(count_w), 32'(to_bcd(m_cnt[0])));
        chk({tag, ".cnt_s"}, 32'(count_s), 32'(to_bcd(m_cnt[1])));
        chk({tag, ".evt_w"}, 32'(evt_w), 32'(m_evt[0]));
        chk({tag, ".evt_s"}, 32'(evt_s), 32'(m_evt[1]));
        chk({tag, ".ovf_w"}, 32'(ovf_w), 32'(m_ovf[0]));
        chk({tag, ".ovf_s"}, 32'(ovf_s), 32'(m_ovf[1]));
`ifdef SEVEN_SEG_EN
        for (int i = 0; i < D; i++) begin
            int p;
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            chk({tag, ".hex_w"}, 32'(hex_w[7*i +: 7]), 32'(seg_of((m_cnt[0] / p) % 10)));
            chk({tag, ".hex_s"}, 32'(hex_s[7*i +: 7]), 32'(seg_of((m_cnt[1] / p) % 10)));
        end
`endif
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
            m_evt[k] = 0;
        end
        m_prev = 0;
    endfunction

    // One clock: apply inputs, advance the model at the edge, check after it.
    task automatic cycle(input bit s, input bit en, input bit clr, input string tag);
        S   = s;
        EN  = en;
        CLR = clr;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
                m_evt[k] = 0;
            end else if (en && s && !m_prev) begin
                m_evt[k] = 1;
                if (m_cnt[k] == maxv) begin
                    m_ovf[k] = 1;
                    m_cnt[k] = (k == 1) ? maxv : 0;
                end else begin
                    m_cnt[k]++;
                end
            end else begin
                m_evt[k] = 0;
            end
        end
        m_prev = s;
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset between edges, visible without any clock.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        maxv = 10 ** D - 1;
        model_reset();

        // Reset held with S and EN high, before the first clock edge.
        #3;
        check_all("reset");
        @(negedge CLK);
        RST = 1'b1;
        cycle(0, 1, 0, "idle");

        // Held run of five cycles gives one event.
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, "held");
        cycle(0, 1, 0, "held_end");
        chk("held.count", 32'(count_w), 32'h01);

        // Nine more runs: ten in total.
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, 0, "ten");
            cycle(0, 1, 0, "ten_gap");
        end
        chk("ten.count", 32'(count_w), 32'h10);
        chk("ten.ovf", 32'(ovf_w), 32'h0);

        // Preload to 99, then overflow.
        cycle(1, 1, 1, "clr0");
        cycle(0, 1, 0, "clr0_gap");
        for (int i = 0; i < 99; i++) begin
            cycle(1, 1, 0, "pre");
            cycle(0, 1, 0, "pre_gap");
        end
        chk("pre.count", 32'(count_w), 32'h99);
        cycle(1, 1, 0, "ovf");
        chk("ovf.wrap_cnt", 32'(count_w), 32'h00);
        chk("ovf.wrap_evt", 32'(evt_w), 32'h1);
        chk("ovf.sat_cnt", 32'(count_s), 32'h99);
        chk("ovf.sat_ovf", 32'(ovf_s), 32'h1);
        cycle(0, 1, 0, "ovf_gap");
        cycle(1, 1, 0, "ovf_sticky");
        cycle(0, 1, 0, "ovf_sticky_gap");

        // Clear on the same edge S rises; the run is discarded.
        cycle(1, 1, 1, "clrcol");
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, "clrcol_hold");
        chk("clrcol.count", 32'(count_w), 32'h0);
        chk("clrcol.ovf", 32'(ovf_s), 32'h0);
        cycle(0, 1, 0, "clrcol_end");

        // Rise while disabled, enable mid-run: no count.
        cycle(1, 0, 0, "en_off");
        cycle(1, 1, 0, "en_on");
        cycle(1, 1, 0, "en_on2");
        cycle(0, 1, 0, "en_end");
        chk("en.count", 32'(count_w), 32'h0);

        for (int i = 0; i < 7; i++) begin
            cycle(1, 1, 0, "seven");
            cycle(0, 1, 0, "seven_gap");
        end
        chk("seven.count", 32'(count_w), 32'h07);
`ifdef SEVEN_SEG_EN
        chk("seven.hex0", 32'(hex_w[6:0]), 32'(7'b1111000));
        chk("seven.hex1", 32'(hex_w[13:7]), 32'(7'b1000000));
`endif

        // Mid-count asynchronous reset; count resumes on first S after release.
        cycle(1, 1, 0, "pre_rst");
        async_reset("midrst");
        cycle(1, 1, 0, "post_rst");
        chk("post_rst.count", 32'(count_w), 32'h01);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            bit s, en, clr;
            s   = ($urandom_range(0, 2) != 0);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 59) == 0);
            cycle(s, en, clr, "rand");
            if ($urandom_range(0, 799) == 0) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
